// File: rtl/dmem_mgm.sv
// dmem_mgm: data-memory manager between the core's LOAD/STORE requests and a
// synchronous single-port word RAM with byte enables.
//   clk, rst (sync, active-low)          : clock and reset
//   req, we, func3, addr, wdata          : request from the core, held until ack
//   rdata, ack, err, busy                : extended load result and handshake
//   ram_en, ram_we, ram_addr, ram_be,
//   ram_wdata, ram_rdata                 : RAM port (read data one cycle after strobe)
module dmem_mgm #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [2:0]        func3,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              ack,
    output logic              err,
    output logic              busy,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [3:0]        ram_be,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    typedef enum logic [2:0] {IDLE, ACC2, RD1, RD2, ACK} state_t;
    state_t state, nxt;
    logic [1:0]        off;
    logic [3:0]        m;
    logic [7:0]        lanes;
    logic              illegal, mis, first, second, err_q;
    logic [ADDR_W-1:0] word;
    logic [31:0]       d1, hi, lo, raw, ld;
    logic              unused_hi;

    assign unused_hi = ^addr[31:ADDR_W+2];
    assign off       = addr[1:0];
    assign word      = addr[ADDR_W+1:2];
    assign m         = func3[1] ? 4'b1111 : func3[0] ? 4'b0011 : 4'b0001;
    assign lanes     = {4'b0000, m} << off;
    assign mis       = |lanes[7:4];
    assign illegal   = (func3[1:0] == 2'b11) || (func3[2] && (func3[1] || we));
    // Access cycles are suppressed combinationally while reset is asserted
    assign first     = rst && state == IDLE && req && !illegal;
    assign second    = rst && state == ACC2;

    // Loads: aligned result comes from the word just read; split loads join
    // the second word (arriving in RD2) above the captured first word.
    assign hi  = state == RD2 ? ram_rdata : 32'h0;
    assign lo  = state == RD2 ? d1 : ram_rdata;
    assign raw = 32'({hi, lo} >> {off, 3'b000});
    assign ld  = func3[1] ? raw :
                 func3[0] ? {{16{~func3[2] & raw[15]}}, raw[15:0]} :
                            {{24{~func3[2] & raw[7]}}, raw[7:0]};

    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE: if (req) nxt = illegal ? ACK : mis ? ACC2 : we ? ACK : RD1;
            ACC2: nxt = we ? ACK : RD2;
            RD1:  nxt = ACK;
            RD2:  nxt = ACK;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = state != IDLE;
        ack       = state == ACK;
        err       = ack && err_q;
        ram_en    = first || second;
        ram_we    = ram_en && we;
        ram_addr  = second ? word + ADDR_W'(1) : word;
        ram_be    = first ? lanes[3:0] : second ? lanes[7:4] : 4'b0000;
        ram_wdata = !we ? 32'h0 :
                    first ? wdata << {off, 3'b000} :
                    second ? wdata >> (6'd32 - {1'b0, off, 3'b000}) : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata <= 32'h0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE && req) err_q <= illegal;
            if (state == IDLE && req && illegal) rdata <= 32'h0;
            if (state == ACC2) d1 <= ram_rdata;
            if (state == RD1 || state == RD2) rdata <= ld;
        end
    end
endmodule

// File: doc/dmem_mgm.md
# dmem_mgm

Data-memory manager for the myOwnMPU core. It services the LOAD/STORE requests issued by `ctrl` and drives a synchronous single-port word RAM with byte enables. It handles byte, half and word accesses, sign or zero extension, and misaligned accesses that span two words, splitting them into two RAM cycles. While it works it holds `busy` so the core stalls in its load phase.

## Interface
Parameters:
- `ADDR_W`, default 10: RAM word-address width (4 KiB RAM at the default).

Ports:
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous, active-low reset.
- `req` in 1: access request. The core holds it, with all fields stable, until `ack`.
- `we` in 1: 1 = store, 0 = load.
- `func3` in 3: access width. Load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Store: 000 SB, 001 SH, 010 SW.
- `addr` in 32: byte address. Byte offset `off` = `addr[1:0]`; word index = `addr[ADDR_W+1:2]`.
- `wdata` in 32: store data, right-aligned.
- `rdata` out 32: registered, extended load result.
- `ack` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse coincident with `ack` for an illegal `func3`.
- `busy` out 1: high whenever state ≠ IDLE.
- `ram_en` out 1: RAM access strobe, combinational.
- `ram_we` out 1: RAM write.
- `ram_addr` out ADDR_W: RAM word address.
- `ram_be` out 4: byte enables. Bit i selects bits [8i+7:8i].
- `ram_wdata` out 32: lane-aligned write data.
- `ram_rdata` in 32: RAM read data, valid one cycle after a read strobe.

## Operation
- Memory is little-endian.
- Access mask `m`: 0001 for byte, 0011 for half, 1111 for word. The lane pattern is `m << off` over 8 bits.
  - Low nibble: first access at word W.
  - High nibble: second access at W+1 mod 2^ADDR_W.
  - A nonzero high nibble means the access is misaligned: LH/SH at off=3, or LW/SW at off≠0. Byte accesses are never split.
- Store data: first access `ram_wdata = wdata << 8*off`; second access `ram_wdata = wdata >> 8*(4-off)`.
- Load assembly: `({d2,d1} >> 8*off)`, truncated to the access width, then sign-extended (LB, LH) or zero-extended (LBU, LHU). For an aligned load, `d2` is don't-care.
- Illegal `func3` (011, 110, 111; also 100/101 with `we`=1):
  - No RAM strobe.
  - `ack`=1 and `err`=1, `rdata`=0.
- FSM states: IDLE, ACC2, RD1, RD2, ACK.
  - IDLE with `req`=1: issue the first access combinationally in that same cycle.
    - Illegal request → ACK (with err).
    - Aligned store → ACK.
    - Misaligned store or load → ACC2.
    - Aligned load → RD1.
  - ACC2: issue the second access. Capture `d1` if it is a load.
    - Store → ACK.
    - Load → RD2.
  - RD1: capture `d1`, register `rdata` → ACK.
  - RD2: capture `d2`, register `rdata` → ACK.
  - ACK: `ack`=1 → IDLE. `req` is not sampled in ACK.
- `ram_en`, `ram_we`, `ram_be` and `ram_wdata` are 0 outside access cycles.

## Timing
- Request sampled in IDLE at cycle T.
- Ack cycle by access type:
  - Aligned store: T+1.
  - Misaligned store: T+2.
  - Aligned load: T+2.
  - Misaligned load: T+3.
  - Illegal: T+1.
- `rdata` is valid from the ack cycle and holds until the next load completes.
- Back-to-back operation: the next request is accepted at the earliest in the cycle after ACK.
- Reset values: state IDLE; `rdata`=0; `ack`, `err`, `busy`=0.
- While `rst`=0, `ram_en` and `ram_we` are forced to 0 combinationally.
- Reset mid-operation: abort. No further RAM cycles and no `ack`. A split store may remain half-written; this is accepted.
- `req` falling before `ack`: the FSM still completes and pulses `ack`.

## Test plan
- Aligned word store then load:
  - Stimulus: SW 0xDEADBEEF at addr 0x10, then LW at 0x10.
  - Required: the store drives `ram_addr`=4, `ram_be`=1111 in cycle T, with `ack` at T+1. The load returns `rdata`=0xDEADBEEF with `ack` at T+2.
- Byte load extension:
  - Stimulus: word 4 = 0xDEADBEEF; LB at 0x13, then LBU at 0x13.
  - Required: LB → 0xFFFFFFDE, LBU → 0x000000DE. LH at 0x12 → 0xFFFFDEAD.
- Misaligned load:
  - Stimulus: word 4 = 0xDEADBEEF, word 5 = 0x11223344; LW at 0x11.
  - Required: reads at `ram_addr` 4 (T) and 5 (T+1); `rdata`=0x44DEADBE with `ack` at T+3.
- Misaligned store:
  - Stimulus: SH 0x0000CAFE at 0x13.
  - Required:
    - T: `ram_addr`=4, `ram_be`=1000, `ram_wdata[31:24]`=0xFE.
    - T+1: `ram_addr`=5, `ram_be`=0001, `ram_wdata[7:0]`=0xCA.
    - `ack` at T+2.
- Wrap and illegal:
  - Wrap stimulus: LW at 0xFFD with `ADDR_W`=10. Required: `ram_addr` 0x3FF, then 0x000.
  - Illegal stimulus: `func3`=011. Required: `ack`=`err`=1 at T+1, `ram_en` never asserted, `rdata`=0.
- Reset mid-access:
  - Stimulus: `rst`=0 in the ACC2 cycle of a misaligned load.
  - Required: next cycle state IDLE, `busy`=0, `rdata`=0, no `ack`, `ram_en`=0 during reset.
